// File: rtl/wfg_drive_spi_gen.sv
// Run-time configurable SPI output driver: one stream word is pulled per pattern
// sync and shifted out with the word length, mode, bit order and divider latched at the handshake.
module wfg_drive_spi_gen #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int NUM_CS          = 4,
  parameter int DIV_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ctrl_en_i,
  input  logic                       ctrl_cpol_i,
  input  logic                       ctrl_cpha_i,
  input  logic                       ctrl_lsbfirst_i,
  input  logic [1:0]                 ctrl_dff_i,
  input  logic [3:0]                 ctrl_cs_sel_i,
  input  logic [DIV_WIDTH-1:0]       ctrl_div_i,
  input  logic                       wfg_pat_sync_i,
  output logic                       wfg_drive_spi_axis_tready,
  input  logic                       wfg_drive_spi_axis_tvalid,
  input  logic [AXIS_DATA_WIDTH-1:0] wfg_drive_spi_axis_tdata,
  output logic                       wfg_drive_spi_sclk_o,
  output logic [NUM_CS-1:0]          wfg_drive_spi_cs_no,
  output logic                       wfg_drive_spi_sdo_o,
  output logic                       wfg_drive_spi_sdo_en_o,
  output logic                       busy_o,
  output logic                       underflow_o,
  output logic                       overrun_o
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t               state_q;
  logic [DIV_WIDTH-1:0] halfCnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [5:0]           kCnt_q;
  logic [31:0]          data_q;
  logic [1:0]           dff_q;
  logic                 cpol_q;
  logic                 cpha_q;
  logic                 lsb_q;
  logic                 sclk_q;
  logic                 sdo_q;
  logic                 sdoEn_q;
  logic                 busy_q;
  logic                 underflow_q;
  logic                 overrun_q;
  logic [NUM_CS-1:0]    csN_q;
  logic [NUM_CS-1:0]    csN_d;

  logic                 halfDone;
  logic [5:0]           kNext;
  logic [5:0]           lastK;
  logic [5:0]           nBits;
  logic [5:0]           nBitsIn;
  logic                 handshake;

  // Bit i of the transmit sequence, counted from the first bit sent.
  function automatic logic pickBit(input logic [31:0] d, input logic [4:0] i,
                                   input logic lsb, input logic [5:0] n);
    logic [4:0] pos;
    pos = lsb ? i : 5'(n - 6'd1 - {1'b0, i});
    return d[pos];
  endfunction

  assign halfDone  = (halfCnt_q == div_q);
  assign kNext     = kCnt_q + 6'd1;
  assign lastK     = {dff_q, 4'hF};
  assign nBits     = {(3'(dff_q) + 3'd1), 3'b000};
  assign nBitsIn   = {(3'(ctrl_dff_i) + 3'd1), 3'b000};
  assign handshake = (state_q == IDLE) && ctrl_en_i && wfg_pat_sync_i
                     && wfg_drive_spi_axis_tvalid;

  // Out-of-range selects leave every line deasserted while the transfer still runs.
  always_comb begin
    csN_d = '1;
    for (int j = 0; j < NUM_CS; j++) begin
      if (ctrl_cs_sel_i == 4'(j)) csN_d[j] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      halfCnt_q   <= '0;
      div_q       <= '0;
      kCnt_q      <= '0;
      data_q      <= '0;
      dff_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      sclk_q      <= 1'b0;
      sdo_q       <= 1'b0;
      sdoEn_q     <= 1'b0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      overrun_q   <= 1'b0;
      csN_q       <= '1;
    end else begin
      underflow_q <= 1'b0;
      overrun_q   <= wfg_pat_sync_i && (state_q != IDLE);
      if ((state_q != IDLE) && !ctrl_en_i) begin
        state_q   <= IDLE;
        halfCnt_q <= '0;
        kCnt_q    <= '0;
        sdo_q     <= 1'b0;
        sdoEn_q   <= 1'b0;
        busy_q    <= 1'b0;
        csN_q     <= '1;
      end else begin
        case (state_q)
          IDLE: begin
            if (handshake) begin
              state_q   <= SETUP;
              halfCnt_q <= '0;
              kCnt_q    <= '0;
              data_q    <= wfg_drive_spi_axis_tdata[31:0];
              dff_q     <= ctrl_dff_i;
              cpol_q    <= ctrl_cpol_i;
              cpha_q    <= ctrl_cpha_i;
              lsb_q     <= ctrl_lsbfirst_i;
              div_q     <= ctrl_div_i;
              sclk_q    <= ctrl_cpol_i;
              sdo_q     <= ctrl_cpha_i ? 1'b0 :
                           pickBit(wfg_drive_spi_axis_tdata[31:0], 5'd0,
                                   ctrl_lsbfirst_i, nBitsIn);
              sdoEn_q   <= 1'b1;
              busy_q    <= 1'b1;
              csN_q     <= csN_d;
            end else if (wfg_pat_sync_i && ctrl_en_i) begin
              underflow_q <= 1'b1;
            end
          end
          SETUP: begin
            if (halfDone) begin
              state_q   <= SHIFT;
              halfCnt_q <= '0;
              kCnt_q    <= '0;
              sclk_q    <= ~sclk_q;
              if (cpha_q) sdo_q <= pickBit(data_q, 5'd0, lsb_q, nBits);
            end else begin
              halfCnt_q <= halfCnt_q + DIV_WIDTH'(1);
            end
          end
          SHIFT: begin
            if (halfDone) begin
              halfCnt_q <= '0;
              if (kCnt_q == lastK) begin
                state_q <= HOLD;
                sclk_q  <= cpol_q;
              end else begin
                kCnt_q <= kNext;
                sclk_q <= ~sclk_q;
                // Even half-periods open with a leading edge, odd ones with a trailing edge.
                if (cpha_q && !kNext[0]) begin
                  sdo_q <= pickBit(data_q, kNext[5:1], lsb_q, nBits);
                end else if (!cpha_q && kNext[0] && (kNext != lastK)) begin
                  sdo_q <= pickBit(data_q, kNext[5:1] + 5'd1, lsb_q, nBits);
                end
              end
            end else begin
              halfCnt_q <= halfCnt_q + DIV_WIDTH'(1);
            end
          end
          HOLD: begin
            if (halfDone) begin
              state_q   <= IDLE;
              halfCnt_q <= '0;
              kCnt_q    <= '0;
              sdo_q     <= 1'b0;
              sdoEn_q   <= 1'b0;
              busy_q    <= 1'b0;
              csN_q     <= '1;
            end else begin
              halfCnt_q <= halfCnt_q + DIV_WIDTH'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wfg_drive_spi_axis_tready = (state_q == IDLE) && ctrl_en_i && wfg_pat_sync_i;
  assign wfg_drive_spi_sclk_o      = (state_q == IDLE) ? ctrl_cpol_i : sclk_q;
  assign wfg_drive_spi_cs_no       = csN_q;
  assign wfg_drive_spi_sdo_o       = sdo_q;
  assign wfg_drive_spi_sdo_en_o    = sdoEn_q;
  assign busy_o                    = busy_q;
  assign underflow_o               = underflow_q;
  assign overrun_o                 = overrun_q;

endmodule

// File: tb/tb_wfg_drive_spi_gen.sv
// Directed bench for wfg_drive_spi_gen: transfers in several modes, sync errors,
// back-to-back words, invalid chip select and aborts by enable and by reset.
module tb_wfg_drive_spi_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ctrl_en_i = 1'b0;
  logic        ctrl_cpol_i = 1'b0;
  logic        ctrl_cpha_i = 1'b0;
  logic        ctrl_lsbfirst_i = 1'b0;
  logic [1:0]  ctrl_dff_i = 2'd0;
  logic [3:0]  ctrl_cs_sel_i = 4'd0;
  logic [7:0]  ctrl_div_i = 8'd0;
  logic        wfg_pat_sync_i = 1'b0;
  logic        wfg_drive_spi_axis_tready;
  logic        wfg_drive_spi_axis_tvalid = 1'b0;
  logic [31:0] wfg_drive_spi_axis_tdata = 32'd0;
  logic        wfg_drive_spi_sclk_o;
  logic [3:0]  wfg_drive_spi_cs_no;
  logic        wfg_drive_spi_sdo_o;
  logic        wfg_drive_spi_sdo_en_o;
  logic        busy_o;
  logic        underflow_o;
  logic        overrun_o;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  wfg_drive_spi_gen #(
    .AXIS_DATA_WIDTH(32),
    .NUM_CS(4),
    .DIV_WIDTH(8)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .ctrl_en_i                 (ctrl_en_i),
    .ctrl_cpol_i               (ctrl_cpol_i),
    .ctrl_cpha_i               (ctrl_cpha_i),
    .ctrl_lsbfirst_i           (ctrl_lsbfirst_i),
    .ctrl_dff_i                (ctrl_dff_i),
    .ctrl_cs_sel_i             (ctrl_cs_sel_i),
    .ctrl_div_i                (ctrl_div_i),
    .wfg_pat_sync_i            (wfg_pat_sync_i),
    .wfg_drive_spi_axis_tready (wfg_drive_spi_axis_tready),
    .wfg_drive_spi_axis_tvalid (wfg_drive_spi_axis_tvalid),
    .wfg_drive_spi_axis_tdata  (wfg_drive_spi_axis_tdata),
    .wfg_drive_spi_sclk_o      (wfg_drive_spi_sclk_o),
    .wfg_drive_spi_cs_no       (wfg_drive_spi_cs_no),
    .wfg_drive_spi_sdo_o       (wfg_drive_spi_sdo_o),
    .wfg_drive_spi_sdo_en_o    (wfg_drive_spi_sdo_en_o),
    .busy_o                    (busy_o),
    .underflow_o               (underflow_o),
    .overrun_o                 (overrun_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Runs one transfer starting at the current falling edge and returns at the
  // falling edge of the first idle cycle, so two calls in a row are back-to-back.
  task automatic applyStimulus(input string name, input logic cpol, input logic cpha,
                               input logic lsb, input logic [1:0] dff, input logic [7:0] div,
                               input logic [31:0] data, input logic [3:0] sel,
                               input int overrunAt);
    int n, h, expCycles, busyCycles, csCycles, edges, nb;
    logic [31:0] rx, mask;
    logic [3:0] expCs;
    logic prevSclk, leading;
    n = 8 * (dff + 1);
    h = div + 1;
    expCycles = h * (2 * n + 2);
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    expCs = (sel < 4'd4) ? ~(4'b0001 << sel) : 4'hF;
    busyCycles = 0; csCycles = 0; edges = 0; nb = 0; rx = 0;

    ctrl_cpol_i = cpol; ctrl_cpha_i = cpha; ctrl_lsbfirst_i = lsb;
    ctrl_dff_i = dff; ctrl_div_i = div; ctrl_cs_sel_i = sel;
    wfg_drive_spi_axis_tdata = data; wfg_drive_spi_axis_tvalid = 1'b1;
    wfg_pat_sync_i = 1'b1;
    #1;
    checkOutput({name, " idle sclk"}, 32'(wfg_drive_spi_sclk_o), 32'(cpol));
    checkOutput({name, " tready"}, 32'(wfg_drive_spi_axis_tready), 32'd1);
    @(negedge clk);
    wfg_pat_sync_i = 1'b0;
    wfg_drive_spi_axis_tvalid = 1'b0;
    wfg_drive_spi_axis_tdata = 32'hFFFF_FFFF;
    ctrl_cpol_i = ~cpol; ctrl_lsbfirst_i = ~lsb; ctrl_cs_sel_i = 4'd0;
    prevSclk = cpol;

    for (int c = 1; c <= 400; c++) begin
      if (!busy_o) break;
      busyCycles++;
      if (wfg_drive_spi_cs_no == expCs && wfg_drive_spi_sdo_en_o) csCycles++;
      if (wfg_drive_spi_sclk_o != prevSclk) begin
        edges++;
        leading = (wfg_drive_spi_sclk_o != cpol);
        if ((cpha ? !leading : leading) && nb < 32) begin
          if (lsb) rx[nb] = wfg_drive_spi_sdo_o;
          else     rx = {rx[30:0], wfg_drive_spi_sdo_o};
          nb++;
        end
      end
      prevSclk = wfg_drive_spi_sclk_o;
      if (c == overrunAt) begin
        wfg_pat_sync_i = 1'b1;
        #1 checkOutput({name, " busy tready"}, 32'(wfg_drive_spi_axis_tready), 32'd0);
      end else if (c == overrunAt + 1) begin
        wfg_pat_sync_i = 1'b0;
        checkOutput({name, " overrun pulse"}, 32'(overrun_o), 32'd1);
      end else if (c == overrunAt + 2) begin
        checkOutput({name, " overrun end"}, 32'(overrun_o), 32'd0);
      end
      @(negedge clk);
    end
    ctrl_cpol_i = cpol;
    #1;
    checkOutput({name, " done"}, 32'(busy_o), 32'd0);
    checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expCycles));
    checkOutput({name, " cs cycles"}, 32'(csCycles), 32'(expCycles));
    checkOutput({name, " sclk edges"}, 32'(edges), 32'(2 * n));
    checkOutput({name, " bits"}, 32'(nb), 32'(n));
    checkOutput({name, " word"}, rx & mask, data & mask);
    checkOutput({name, " end cs"}, 32'(wfg_drive_spi_cs_no), 32'hF);
    checkOutput({name, " end sdo_en"}, 32'(wfg_drive_spi_sdo_en_o), 32'd0);
    checkOutput({name, " end sclk"}, 32'(wfg_drive_spi_sclk_o), 32'(cpol));
  endtask

  task automatic applyUnderflow();
    @(negedge clk);
    wfg_drive_spi_axis_tvalid = 1'b0;
    wfg_pat_sync_i = 1'b1;
    #1 checkOutput("uf tready", 32'(wfg_drive_spi_axis_tready), 32'd1);
    @(negedge clk);
    wfg_pat_sync_i = 1'b0;
    checkOutput("uf pulse", 32'(underflow_o), 32'd1);
    checkOutput("uf busy", 32'(busy_o), 32'd0);
    checkOutput("uf cs", 32'(wfg_drive_spi_cs_no), 32'hF);
    @(negedge clk);
    checkOutput("uf pulse end", 32'(underflow_o), 32'd0);
  endtask

  // Mode 2, N=8, div=1: at cycle 7 the third sclk toggle has just driven sclk low.
  task automatic applyAbort(input logic useReset);
    string name;
    name = useReset ? "rst abort" : "en abort";
    @(negedge clk);
    ctrl_cpol_i = 1'b1; ctrl_cpha_i = 1'b0; ctrl_lsbfirst_i = 1'b0;
    ctrl_dff_i = 2'd0; ctrl_div_i = 8'd1; ctrl_cs_sel_i = 4'd1;
    wfg_drive_spi_axis_tdata = 32'h5A; wfg_drive_spi_axis_tvalid = 1'b1;
    wfg_pat_sync_i = 1'b1;
    @(negedge clk);
    wfg_pat_sync_i = 1'b0; wfg_drive_spi_axis_tvalid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput({name, " pre busy"}, 32'(busy_o), 32'd1);
    checkOutput({name, " pre cs"}, 32'(wfg_drive_spi_cs_no), 32'hD);
    checkOutput({name, " pre sclk"}, 32'(wfg_drive_spi_sclk_o), 32'd0);
    if (useReset) begin
      rst_n = 1'b0;
      #1;
    end else begin
      ctrl_en_i = 1'b0;
      @(negedge clk);
    end
    checkOutput({name, " cs"}, 32'(wfg_drive_spi_cs_no), 32'hF);
    checkOutput({name, " sdo_en"}, 32'(wfg_drive_spi_sdo_en_o), 32'd0);
    checkOutput({name, " sdo"}, 32'(wfg_drive_spi_sdo_o), 32'd0);
    checkOutput({name, " sclk"}, 32'(wfg_drive_spi_sclk_o), 32'd1);
    checkOutput({name, " busy"}, 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ctrl_en_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset cs", 32'(wfg_drive_spi_cs_no), 32'hF);
    checkOutput("reset sdo", 32'(wfg_drive_spi_sdo_o), 32'd0);
    checkOutput("reset sdo_en", 32'(wfg_drive_spi_sdo_en_o), 32'd0);
    checkOutput("reset busy", 32'(busy_o), 32'd0);
    checkOutput("reset underflow", 32'(underflow_o), 32'd0);
    checkOutput("reset overrun", 32'(overrun_o), 32'd0);
    checkOutput("reset sclk lo", 32'(wfg_drive_spi_sclk_o), 32'd0);
    ctrl_cpol_i = 1'b1;
    #1 checkOutput("reset sclk hi", 32'(wfg_drive_spi_sclk_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ctrl_en_i = 1'b1;
    @(negedge clk);

    applyStimulus("mode0", 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 32'h0000_00A5, 4'd2, -10);
    repeat (3) @(negedge clk);
    applyStimulus("mode3", 1'b1, 1'b1, 1'b1, 2'd1, 8'd0, 32'h0000_1234, 4'd0, -10);
    repeat (2) @(negedge clk);
    applyStimulus("n32", 1'b0, 1'b1, 1'b0, 2'd3, 8'd3, 32'hDEAD_BEEF, 4'd3, 50);
    repeat (2) @(negedge clk);
    applyUnderflow();
    applyStimulus("b2b first", 1'b1, 1'b0, 1'b0, 2'd2, 8'd2, 32'h00C3_5A96, 4'd1, -10);
    applyStimulus("b2b bad sel", 1'b0, 1'b0, 1'b1, 2'd0, 8'd0, 32'h0000_003C, 4'd7, -10);
    applyAbort(1'b0);
    applyAbort(1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
